// File: rtl/clk_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gen_pkg
//  Description : Shared mode encodings, width helper and power-on tuning-word
//                calculation for the clock-enable generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_gen_pkg;

    // Channel operating modes
    localparam logic MODE_NCO = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Index width for n items, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // round(f_out * 2^acc_w / f_clk), clamped to 1 .. 2^(acc_w-1) so the
    // accumulator never stalls and never ticks faster than every other cycle
    function automatic longint unsigned calc_inc(input longint unsigned f_clk,
                                                 input longint unsigned f_out,
                                                 input int unsigned     acc_w);
        longint unsigned num;
        longint unsigned inc;
        longint unsigned max_inc;
        num     = f_out << acc_w;
        inc     = (num + (f_clk >> 1)) / f_clk;
        max_inc = 64'd1 << (acc_w - 1);
        if (inc < 64'd1) begin
            inc = 64'd1;
        end else if (inc > max_inc) begin
            inc = max_inc;
        end
        return inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gen_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gen_channel
//  Description : One clock-enable channel: NCO or integer-divide accumulator,
//                active/pending tuning word, registered tick/clk_out/locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gen_channel
    import clk_gen_pkg::*;
#(
    parameter int unsigned      ACC_W    = 32,
    parameter logic [ACC_W-1:0] DEF_INC  = ACC_W'(1),
    parameter logic             DEF_MODE = MODE_NCO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic             i_wr_mode,
    input  logic [ACC_W-1:0] i_wr_inc,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_locked
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_mode;
    logic [ACC_W-1:0] r_pend_inc;
    logic             r_pend_mode;
    logic             r_pend_vld;
    logic             r_tick;
    logic             r_clk_out;
    logic             r_locked;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_n;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_wrap;
    logic             w_clk_next;
    logic             w_commit;

    // Next accumulator value, wrap detect and square-wave level for the active mode
    always_comb begin
        w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
        w_n        = (r_inc == '0) ? ACC_W'(1) : r_inc;
        w_wrap     = 1'b0;
        w_acc_next = r_acc;
        w_clk_next = 1'b0;
        if (r_mode == MODE_NCO) begin
            w_wrap     = w_sum[ACC_W];
            w_acc_next = w_sum[ACC_W-1:0];
            w_clk_next = w_sum[ACC_W-1];
        end else begin
            // >= rather than == so a smaller N committed while idle still wraps
            w_wrap     = (r_acc >= (w_n - ACC_W'(1)));
            w_acc_next = w_wrap ? '0 : (r_acc + ACC_W'(1));
            w_clk_next = (w_acc_next < (w_n >> 1));
        end
        // A stopped channel has no wrap to wait for, so it commits at once
        w_commit = r_pend_vld && (w_wrap || !i_en);
    end

    // Accumulator, tuning-word handover and registered outputs; a write in the
    // same cycle as a commit wins for the pending slot and for locked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_inc       <= DEF_INC;
            r_mode      <= DEF_MODE;
            r_pend_inc  <= '0;
            r_pend_mode <= MODE_NCO;
            r_pend_vld  <= 1'b0;
            r_tick      <= 1'b0;
            r_clk_out   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            if (i_en) begin
                r_acc     <= w_acc_next;
                r_tick    <= w_wrap;
                r_clk_out <= w_clk_next;
            end else begin
                r_tick    <= 1'b0;
            end
            if (w_commit) begin
                r_inc      <= r_pend_inc;
                r_mode     <= r_pend_mode;
                r_pend_vld <= 1'b0;
                r_locked   <= 1'b1;
                if (r_pend_mode != r_mode) begin
                    r_acc <= '0;
                end
            end
            if (i_wr) begin
                r_pend_inc  <= i_wr_inc;
                r_pend_mode <= i_wr_mode;
                r_pend_vld  <= 1'b1;
                r_locked    <= 1'b0;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
    assign o_locked  = r_locked;

endmodule
`default_nettype wire

// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_enable_gen
//  Description : Multi-channel runtime-programmable clock-enable generator;
//                decodes tuning-word writes onto NCH independent channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned F_CLK     = 100000000,
    parameter int unsigned NCH       = 4,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned F_DEFAULT = 1000000,
    parameter bit          DEF_MODE  = 1'b0,
    localparam int unsigned CH_W     = clog2_min1(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic             wr_mode,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic [NCH-1:0]   ch_en,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   locked
);

    localparam logic [ACC_W-1:0] c_def_inc =
        ACC_W'(calc_inc(64'(F_CLK), 64'(F_DEFAULT), ACC_W));

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic w_wr_sel;

        // Channel indices beyond NCH never match, so such writes are dropped
        assign w_wr_sel = wr_en && (wr_ch == CH_W'(gi));

        clk_gen_channel #(
            .ACC_W    (ACC_W),
            .DEF_INC  (c_def_inc),
            .DEF_MODE (DEF_MODE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_en      (ch_en[gi]),
            .i_wr      (w_wr_sel),
            .i_wr_mode (wr_mode),
            .i_wr_inc  (wr_inc),
            .o_tick    (tick[gi]),
            .o_clk_out (clk_out[gi]),
            .o_locked  (locked[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_enable_gen
//  Description : Self-checking bench for clk_enable_gen (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_enable_gen;
    import clk_gen_pkg::*;

    localparam int unsigned NCH   = 4;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic             wr_mode;
    logic [ACC_W-1:0] wr_inc;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   locked;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    typedef struct {
        int          ch;
        bit          mode;
        logic [31:0] inc;
        int          per;
        int          high;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    clk_enable_gen #(
        .F_CLK     (100000000),
        .NCH       (NCH),
        .ACC_W     (ACC_W),
        .F_DEFAULT (1000000),
        .DEF_MODE  (1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_mode (wr_mode),
        .wr_inc  (wr_inc),
        .ch_en   (ch_en),
        .tick    (tick),
        .clk_out (clk_out),
        .locked  (locked)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act,
                               input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick(input int ch, input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step();
            n++;
            if (tick[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_locked(input int ch, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step();
            if (locked[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic write(input int ch, input bit mode, input logic [31:0] inc);
        wr_ch   = CH_W'(ch);
        wr_mode = mode;
        wr_inc  = inc;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    // Expected tick spacing is queued up front and popped as each tick appears
    task automatic measure(input string name, input int ch, input int per, input int high);
        int n;
        bit ok;
        int cyc;
        int hi;
        wait_tick(ch, 400, n, ok);
        check({name, " align"}, ok, 1);
        if (!ok) return;
        for (int k = 0; k < 4; k++) exp_q.push_back(per);
        n   = 0;
        cyc = 0;
        hi  = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            step();
            cyc++;
            n++;
            hi += int'(clk_out[ch]);
            if (tick[ch]) begin
                check({name, " period"}, n, exp_q.pop_front());
                n = 0;
            end
        end
        check({name, " ticks pending"}, exp_q.size(), 0);
        exp_q.delete();
        check({name, " clk_out high"}, hi, 4 * high);
    endtask

    initial begin
        int cnt[NCH];
        int lk_bad;
        int n;
        int ticks_off;
        int chg;
        bit ok;
        logic held;

        vecs[0] = '{0, MODE_DIV, 32'd5,          5, 2};
        vecs[1] = '{0, MODE_DIV, 32'd0,          1, 0};
        vecs[2] = '{1, MODE_NCO, 32'h4000_0000,  4, 2};
        vecs[3] = '{1, MODE_NCO, 32'h8000_0000,  2, 1};
        vecs[4] = '{0, MODE_DIV, 32'd4,          4, 2};
        vecs[5] = '{0, MODE_DIV, 32'd1,          1, 0};
        vecs[6] = '{1, MODE_DIV, 32'd7,          7, 3};

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_mode = 1'b0;
        wr_inc  = '0;
        ch_en   = '1;
        repeat (3) step();
        check("reset tick", tick, 0);
        check("reset clk_out", clk_out, 0);
        check("reset locked", locked, 0);
        reset = 1'b0;

        // Default 1 MHz from 100 MHz: 100 ticks in 10000 cycles, never locked
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        lk_bad = 0;
        repeat (10000) begin
            step();
            for (int c = 0; c < NCH; c++) cnt[c] += int'(tick[c]);
            if (locked != '0) lk_bad++;
        end
        for (int c = 0; c < NCH; c++) check_range($sformatf("default ticks ch%0d", c), cnt[c], 99, 101);
        check("default locked cycles", lk_bad, 0);

        // Table of tuning words: commit, then tick spacing and duty
        for (int v = 0; v < 7; v++) begin
            write(vecs[v].ch, vecs[v].mode, vecs[v].inc);
            wait_locked(vecs[v].ch, 300, ok);
            check($sformatf("vec%0d locked", v), ok, 1);
            measure($sformatf("vec%0d", v), vecs[v].ch, vecs[v].per, vecs[v].high);
        end

        // Retune mid-period: A then B before the wrap, only B is committed
        write(2, MODE_DIV, 32'd6);
        wait_locked(2, 300, ok);
        check("retune base locked", ok, 1);
        wait_tick(2, 50, n, ok);
        check("retune align", ok, 1);
        step();
        step();
        write(2, MODE_DIV, 32'd10);
        check("retune locked after A", locked[2], 0);
        write(2, MODE_DIV, 32'd3);
        check("retune locked after B", locked[2], 0);
        n      = 4;
        lk_bad = 0;
        ok     = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            n++;
            if (tick[2]) begin
                ok = 1'b1;
                break;
            end
            if (locked[2]) lk_bad++;
        end
        check("retune commit interval", n, 6);
        check("retune early lock", lk_bad, 0);
        check("retune locked at commit", locked[2], 1);
        wait_tick(2, 50, n, ok);
        check("retune B period 1", n, 3);
        wait_tick(2, 50, n, ok);
        check("retune B period 2", n, 3);

        // Pause a divide-by-8 channel for 7 cycles mid-count
        write(3, MODE_DIV, 32'd8);
        wait_locked(3, 300, ok);
        check("pause locked", ok, 1);
        wait_tick(3, 50, n, ok);
        check("pause align", ok, 1);
        repeat (3) step();
        ch_en[3]  = 1'b0;
        held      = clk_out[3];
        ticks_off = 0;
        chg       = 0;
        repeat (7) begin
            step();
            ticks_off += int'(tick[3]);
            if (clk_out[3] != held) chg++;
        end
        check("pause ticks", ticks_off, 0);
        check("pause clk_out changes", chg, 0);
        ch_en[3] = 1'b1;
        wait_tick(3, 50, n, ok);
        check("pause remaining count", n, 5);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset tick", tick, 0);
        check("async reset clk_out", clk_out, 0);
        check("async reset locked", locked, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_tick(2, 300, n, ok);
        check("post reset first tick", n, 100);
        check("post reset locked", locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
